// File: rtl/gen_pattern.sv
// gen_pattern: pixel-clock test-pattern source feeding hdmi_top.
// Consumes the raster position and active size from the timing generator
// and returns one registered 24-bit {R,G,B} value per clock. A debounced
// push button steps through four patterns (border, colour bars, scrolling
// checkerboard, grey ramp). A new selection is only applied at the start
// of a frame, so a pattern never changes partway through a picture.
module gen_pattern #(
    parameter int VIDEO_X_BITWIDTH = 12,
    parameter int VIDEO_Y_BITWIDTH = 11,
    parameter int DEBOUNCE_CYCLES  = 270000,
    parameter int CHECKER_SHIFT    = 5
) (
    input  logic                        I_clk_pixel,
    input  logic                        I_reset,
    input  logic                        I_btn_n,
    input  logic [VIDEO_X_BITWIDTH-1:0] pixX,
    input  logic [VIDEO_Y_BITWIDTH-1:0] pixY,
    input  logic [VIDEO_X_BITWIDTH-1:0] screenWidth,
    input  logic [VIDEO_Y_BITWIDTH-1:0] screenHeight,
    output logic [23:0]                 rgb,
    output logic [1:0]                  pattern,
    output logic [7:0]                  frame_count
);

    // Debounce counter only ever has to reach DEBOUNCE_CYCLES-1.
    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Checker arithmetic only needs the bits up to and including the
    // square-select bit; the truncated sum gives the same bit as the full one.
    localparam int CW = CHECKER_SHIFT + 1;

    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] BLACK = 24'h000000;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                        btn_meta_q, btn_meta_d;
    logic                        btn_sync_q, btn_sync_d;
    logic                        db_level_q, db_level_d;
    logic [DB_W-1:0]             db_cnt_q,   db_cnt_d;
    logic                        pending_q,  pending_d;
    logic [1:0]                  pattern_q,  pattern_d;
    logic [7:0]                  frame_count_q, frame_count_d;
    logic [2:0]                  bar_idx_q,  bar_idx_d;
    logic [VIDEO_X_BITWIDTH-1:0] sub_cnt_q,  sub_cnt_d;
    logic [23:0]                 rgb_q,      rgb_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                        press;
    logic                        frame_start;
    logic                        active;
    logic                        on_border;
    logic [VIDEO_X_BITWIDTH-1:0] w8;
    logic [VIDEO_X_BITWIDTH-1:0] w8_last;
    logic [2:0]                  cur_bar;
    logic [VIDEO_X_BITWIDTH-1:0] cur_sub;
    logic                        checker_x_bit;
    logic                        checker_bit;
    logic [23:0]                 bar_rgb;
    logic [23:0]                 ramp_rgb;

    // Grey ramp: the same low byte of the column on all three channels.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ramp
            assign ramp_rgb[gi*8 +: 8] = pixX[7:0];
        end
    endgenerate

    // Button path: two-flop synchroniser, then a stability counter that
    // only lets the debounced level follow the input after it has held a
    // different value for DEBOUNCE_CYCLES consecutive clocks.
    always_comb begin
        btn_meta_d = I_btn_n;
        btn_sync_d = btn_meta_q;
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        press      = 1'b0;
        if (btn_sync_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = btn_sync_q;
                // Level moves to the synced value; a move to 0 is a press.
                press      = ~btn_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Frame bookkeeping: frame counter, pending request and pattern select.
    // A press in the frame-start cycle is kept for the next frame while the
    // request that was already pending is the one consumed now.
    always_comb begin
        frame_start   = (pixX == '0) && (pixY == '0);
        pattern_d     = pattern_q;
        frame_count_d = frame_count_q;
        pending_d     = pending_q | press;
        if (frame_start) begin
            frame_count_d = frame_count_q + 8'd1;
            pending_d     = press;
            if (pending_q) begin
                pattern_d = pattern_q + 2'd1;
            end
        end
    end

    // Colour-bar position tracker: counts pixels within the current bar
    // instead of dividing the column by the bar width. Column 0 always
    // restarts at bar 0, so a stale count from the previous line is ignored.
    always_comb begin
        w8      = screenWidth >> 3;
        w8_last = w8 - 1'b1;
        cur_bar = (pixX == '0) ? 3'd0 : bar_idx_q;
        cur_sub = (pixX == '0) ? '0   : sub_cnt_q;
        bar_idx_d = cur_bar;
        sub_cnt_d = cur_sub;
        if (active) begin
            if (cur_sub == w8_last) begin
                sub_cnt_d = '0;
                if (cur_bar != 3'd7) begin
                    bar_idx_d = cur_bar + 3'd1;
                end
            end else begin
                sub_cnt_d = cur_sub + 1'b1;
            end
        end
    end

    // Bar colour lookup, left to right.
    always_comb begin
        bar_rgb = BLACK;
        case (cur_bar)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    // Pixel colour for the position presented this clock. It uses the
    // post-update pattern and frame count so pixel (0,0) already belongs
    // to the new frame.
    always_comb begin
        active    = (pixX < screenWidth) && (pixY < screenHeight);
        on_border = (pixX == '0) || (pixX == screenWidth - 1'b1) ||
                    (pixY == '0) || (pixY == screenHeight - 1'b1);
        // Moving the sampling point right by frame_count scrolls the
        // squares left by one pixel per frame.
        checker_x_bit = 1'((pixX[CW-1:0] + CW'(frame_count_d)) >> CHECKER_SHIFT);
        checker_bit   = checker_x_bit ^ pixY[CHECKER_SHIFT];
        rgb_d = BLACK;
        if (active) begin
            case (pattern_d)
                2'd0:    rgb_d = on_border   ? WHITE : BLACK;
                2'd1:    rgb_d = bar_rgb;
                2'd2:    rgb_d = checker_bit ? WHITE : BLACK;
                default: rgb_d = ramp_rgb;
            endcase
        end
    end

    // All state registers; the button path idles at "released".
    always_ff @(posedge I_clk_pixel) begin
        if (I_reset) begin
            btn_meta_q    <= 1'b1;
            btn_sync_q    <= 1'b1;
            db_level_q    <= 1'b1;
            db_cnt_q      <= '0;
            pending_q     <= 1'b0;
            pattern_q     <= 2'd0;
            frame_count_q <= 8'd0;
            bar_idx_q     <= 3'd0;
            sub_cnt_q     <= '0;
            rgb_q         <= 24'h000000;
        end else begin
            btn_meta_q    <= btn_meta_d;
            btn_sync_q    <= btn_sync_d;
            db_level_q    <= db_level_d;
            db_cnt_q      <= db_cnt_d;
            pending_q     <= pending_d;
            pattern_q     <= pattern_d;
            frame_count_q <= frame_count_d;
            bar_idx_q     <= bar_idx_d;
            sub_cnt_q     <= sub_cnt_d;
            rgb_q         <= rgb_d;
        end
    end

    assign rgb         = rgb_q;
    assign pattern     = pattern_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_gen_pattern.sv
// Testbench for gen_pattern: drives a synthetic raster and button and
// compares against a behavioural model of the pattern rules.
module tb_gen_pattern;

    localparam int XW = 12;
    localparam int YW = 11;
    localparam int D  = 16;

    localparam logic [23:0] BAR [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic          clk = 1'b0;
    logic          I_reset;
    logic          I_btn_n;
    logic [XW-1:0] pixX;
    logic [YW-1:0] pixY;
    logic [XW-1:0] screenWidth;
    logic [YW-1:0] screenHeight;
    logic [23:0]   rgb;
    logic [1:0]    pattern;
    logic [7:0]    frame_count;

    always #5 clk = ~clk;

    gen_pattern #(
        .VIDEO_X_BITWIDTH(XW),
        .VIDEO_Y_BITWIDTH(YW),
        .DEBOUNCE_CYCLES (D),
        .CHECKER_SHIFT   (5)
    ) dut (
        .I_clk_pixel (clk),
        .I_reset     (I_reset),
        .I_btn_n     (I_btn_n),
        .pixX        (pixX),
        .pixY        (pixY),
        .screenWidth (screenWidth),
        .screenHeight(screenHeight),
        .rgb         (rgb),
        .pattern     (pattern),
        .frame_count (frame_count)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_pat, m_fc, m_lvl, m_run;
    bit          m_pend;
    int          m_hist[2];
    logic [23:0] m_rgb;

    // Expected colour of one pixel from the pattern rules (bars assume a
    // left-to-right scan starting at column 0).
    function automatic logic [23:0] ref_pixel(int pat, int fc, int x, int y, int w, int h);
        int w8, b, cx;
        logic [7:0] v;
        if (!(x < w && y < h)) return 24'h0;
        case (pat)
            0: return (x == 0 || x == w - 1 || y == 0 || y == h - 1) ? 24'hFFFFFF : 24'h0;
            1: begin
                w8 = w / 8;
                b  = (w8 == 0) ? 0 : x / w8;
                if (b > 7) b = 7;
                return BAR[b];
            end
            2: begin
                cx = (x + fc) % 4096;
                return ((((cx / 32) ^ (y / 32)) & 1) == 1) ? 24'hFFFFFF : 24'h0;
            end
            default: begin
                v = 8'(x);
                return {v, v, v};
            end
        endcase
    endfunction

    // One clock: present a pixel, advance the model, settle past the edge.
    task automatic tick(input int x, input int y);
        int syn;
        bit pr;
        pixX = XW'(x);
        pixY = YW'(y);
        @(posedge clk);
        if (I_reset) begin
            m_hist = '{1, 1};
            m_lvl = 1; m_run = 0; m_pend = 0; m_pat = 0; m_fc = 0; m_rgb = 24'h0;
        end else begin
            // Button seen after a two-sample delay; must differ from the
            // accepted level for D consecutive samples to be accepted.
            syn = m_hist[0];
            m_hist[0] = m_hist[1];
            m_hist[1] = int'(I_btn_n);
            pr = 0;
            if (syn != m_lvl) begin
                m_run++;
                if (m_run == D) begin
                    m_lvl = syn;
                    m_run = 0;
                    pr = (syn == 0);
                end
            end else begin
                m_run = 0;
            end
            if (x == 0 && y == 0) begin
                m_fc = (m_fc + 1) % 256;
                if (m_pend) m_pat = (m_pat + 1) % 4;
                m_pend = pr;
            end else if (pr) begin
                m_pend = 1;
            end
            m_rgb = ref_pixel(m_pat, m_fc, x, y, int'(screenWidth), int'(screenHeight));
        end
        #1;
    endtask

    // Stimulus only: hold the button low for n clocks, then release it long
    // enough for the debouncer to settle back to released.
    task automatic push(input int n, input int x, input int y);
        I_btn_n = 1'b0;
        for (int i = 0; i < n; i++) tick(x + i, y);
        I_btn_n = 1'b1;
        for (int i = 0; i < D + 6; i++) tick(x + n + i, y);
    endtask

    task automatic test_reset;
        I_reset = 1'b1;
        I_btn_n = 1'b1;
        screenWidth = 12'd640;
        screenHeight = 11'd480;
        for (int i = 0; i < 3; i++) tick(3, 3);
        I_reset = 1'b0;
        total++; if (pattern !== 2'd0) begin bad++; $display("FAIL reset_pattern: got %0d want 0", pattern); end
        total++; if (frame_count !== 8'd0) begin bad++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
        total++; if (rgb !== 24'h0) begin bad++; $display("FAIL reset_rgb: got %h want 000000", rgb); end
    endtask

    task automatic test_border;
        int px[6] = '{0, 639, 5, 5, 5, 700};
        int py[6] = '{5, 5, 0, 479, 5, 5};
        logic [23:0] ex[6] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h0, 24'h0};
        int x, y;
        for (int i = 0; i < 6; i++) begin
            tick(px[i], py[i]);
            total++;
            if (rgb !== ex[i]) begin
                bad++; $display("FAIL border_%0d_%0d: got %h want %h", px[i], py[i], rgb, ex[i]);
            end
        end
        for (int i = 0; i < 60; i++) begin
            screenWidth  = XW'($urandom_range(8, 640));
            screenHeight = YW'($urandom_range(8, 480));
            x = $urandom_range(0, int'(screenWidth) + 4);
            y = $urandom_range(0, int'(screenHeight) + 4);
            if (i % 3 == 0) x = int'(screenWidth) - 1;
            if (x == 0 && y == 0) x = 1;
            tick(x, y);
            total++;
            if (rgb !== m_rgb) begin
                bad++; $display("FAIL border_rand (%0d,%0d) w=%0d h=%0d: got %h want %h",
                                x, y, screenWidth, screenHeight, rgb, m_rgb);
            end
        end
        screenWidth  = 12'd640;
        screenHeight = 11'd480;
    endtask

    task automatic test_button;
        push(20, 100, 100);
        total++; if (pattern !== 2'd0) begin bad++; $display("FAIL press_no_early_change: got %0d want 0", pattern); end
        push(20, 100, 120);
        total++; if (pattern !== 2'd0) begin bad++; $display("FAIL second_press_no_change: got %0d want 0", pattern); end
        tick(0, 0);
        total++; if (pattern !== 2'd1) begin bad++; $display("FAIL advance_at_fs: got %0d want 1", pattern); end
        total++; if (rgb !== 24'hFFFFFF) begin bad++; $display("FAIL fs_pixel_uses_new_pattern: got %h want FFFFFF", rgb); end
        total++; if (frame_count !== 8'(m_fc)) begin bad++; $display("FAIL fs_frame_count: got %0d want %0d", frame_count, m_fc); end
        for (int i = 1; i < 6; i++) tick(i, 0);
        tick(0, 0);
        total++; if (pattern !== 2'd1) begin bad++; $display("FAIL single_advance: got %0d want 1", pattern); end
    endtask

    task automatic test_glitch;
        for (int g = 0; g < 3; g++) push(10, 300, 200 + g);
        tick(0, 0);
        total++; if (pattern !== 2'd1) begin bad++; $display("FAIL glitch_ignored: got %0d want 1", pattern); end
    endtask

    task automatic test_bars;
        int xs[5] = '{0, 79, 80, 400, 639};
        logic [23:0] ex[5] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFF0000, 24'h000000};
        for (int y = 10; y < 12; y++) begin
            for (int x = 0; x < 800; x++) begin
                tick(x, y);
                total++;
                if (rgb !== m_rgb) begin
                    bad++; $display("FAIL bars_scan (%0d,%0d): got %h want %h", x, y, rgb, m_rgb);
                end
                for (int k = 0; k < 5; k++) begin
                    if (x == xs[k]) begin
                        total++;
                        if (rgb !== ex[k]) begin
                            bad++; $display("FAIL bars_x%0d: got %h want %h", x, rgb, ex[k]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_fs_press;
        I_btn_n = 1'b0;
        for (int i = 0; i <= D; i++) tick(50 + i, 50);
        tick(0, 0);
        total++; if (pattern !== 2'd1) begin bad++; $display("FAIL press_on_fs_not_now: got %0d want 1", pattern); end
        I_btn_n = 1'b1;
        for (int i = 0; i < D + 6; i++) tick(60 + i, 50);
        tick(0, 0);
        total++; if (pattern !== 2'd2) begin bad++; $display("FAIL press_on_fs_next_frame: got %0d want 2", pattern); end
    endtask

    task automatic test_frame_wrap;
        int guard = 0;
        while (m_fc != 255 && guard < 300) begin
            tick(0, 0);
            tick(1, 0);
            guard++;
        end
        total++; if (frame_count !== 8'd255) begin bad++; $display("FAIL frame_count_before_wrap: got %0d want 255", frame_count); end
        tick(0, 0);
        total++; if (frame_count !== 8'd0) begin bad++; $display("FAIL frame_count_wrap: got %0d want 0", frame_count); end
        total++; if (pattern !== 2'd2) begin bad++; $display("FAIL wrap_pattern_kept: got %0d want 2", pattern); end
    endtask

    task automatic test_checker;
        int x, y;
        tick(32, 0);
        total++; if (rgb !== 24'hFFFFFF) begin bad++; $display("FAIL checker_fc0_32_0: got %h want FFFFFF", rgb); end
        tick(32, 32);
        total++; if (rgb !== 24'h0) begin bad++; $display("FAIL checker_fc0_32_32: got %h want 000000", rgb); end
        tick(0, 0);
        tick(31, 0);
        total++; if (rgb !== 24'hFFFFFF) begin bad++; $display("FAIL checker_fc1_31_0: got %h want FFFFFF", rgb); end
        for (int i = 0; i < 120; i++) begin
            x = $urandom_range(0, 700);
            y = $urandom_range(0, 520);
            if ($urandom_range(0, 19) == 0) begin x = 0; y = 0; end
            tick(x, y);
            total++;
            if (rgb !== m_rgb) begin
                bad++; $display("FAIL checker_rand (%0d,%0d) fc=%0d: got %h want %h", x, y, m_fc, rgb, m_rgb);
            end
        end
    endtask

    task automatic test_ramp;
        int x, y;
        push(20, 10, 10);
        tick(0, 0);
        total++; if (pattern !== 2'd3) begin bad++; $display("FAIL advance_to_ramp: got %0d want 3", pattern); end
        tick(300, 7);
        total++; if (rgb !== 24'h2C2C2C) begin bad++; $display("FAIL ramp_x300: got %h want 2C2C2C", rgb); end
        for (int i = 0; i < 60; i++) begin
            x = $urandom_range(1, 700);
            y = $urandom_range(0, 520);
            tick(x, y);
            total++;
            if (rgb !== m_rgb) begin
                bad++; $display("FAIL ramp_rand (%0d,%0d): got %h want %h", x, y, rgb, m_rgb);
            end
        end
    endtask

    task automatic test_reset_midline;
        tick(200, 100);
        I_reset = 1'b1;
        tick(201, 100);
        I_reset = 1'b0;
        total++; if (rgb !== 24'h0) begin bad++; $display("FAIL midreset_rgb: got %h want 000000", rgb); end
        total++; if (pattern !== 2'd0) begin bad++; $display("FAIL midreset_pattern: got %0d want 0", pattern); end
        total++; if (frame_count !== 8'd0) begin bad++; $display("FAIL midreset_frame_count: got %0d want 0", frame_count); end
        tick(0, 100);
        total++; if (rgb !== 24'hFFFFFF) begin bad++; $display("FAIL resume_border_left: got %h want FFFFFF", rgb); end
        tick(5, 100);
        total++; if (rgb !== 24'h0) begin bad++; $display("FAIL resume_border_inner: got %h want 000000", rgb); end
        tick(639, 100);
        total++; if (rgb !== 24'hFFFFFF) begin bad++; $display("FAIL resume_border_right: got %h want FFFFFF", rgb); end
    endtask

    initial begin
        I_reset      = 1'b1;
        I_btn_n      = 1'b1;
        pixX         = '0;
        pixY         = '0;
        screenWidth  = 12'd640;
        screenHeight = 11'd480;
        test_reset;
        test_border;
        test_button;
        test_glitch;
        test_bars;
        test_fs_press;
        test_frame_wrap;
        test_checker;
        test_ramp;
        test_reset_midline;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
